// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count_ctrl sequencing controller.
package count_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic UP = 1'b0;
   localparam logic DN = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

endpackage

// File: rtl/count_ctrl_if.sv
// Command/status bundle between the control logic (master) and count_ctrl (slave).
interface count_ctrl_if
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             start;
   logic             stop;
   logic             hold;
   logic             dir;
   logic             reload;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, hold, dir, reload, term,
      input  count, busy, done
   );

   modport slave (
      input  start, stop, hold, dir, reload, term,
      output count, busy, done
   );

endinterface

// File: rtl/updown_count.sv
// WIDTH-bit count register with load / increment / decrement / hold and an endpoint compare.
module updown_count #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic [WIDTH-1:0] end_val_i,
   output logic [WIDTH-1:0] count_o,
   output logic             at_end_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (inc_i) begin
         count_d = count_q + WIDTH'(1);
      end else if (dec_i) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o  = count_q;
   assign at_end_o = (count_q == end_val_i);

endmodule

// File: rtl/count_ctrl.sv
// Start/stop/hold sequencer driving an up/down counter to a latched terminal value,
// in one-shot or auto-reload mode, with a registered one-cycle done pulse.
module count_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   count_ctrl_if.slave  ctrl_if
);

   localparam logic [WIDTH-1:0] ZERO = '0;

   state_e           state_q;
   logic             dir_q;
   logic             reload_q;
   logic [WIDTH-1:0] term_q;
   logic             done_q;

   logic             loadEn;
   logic [WIDTH-1:0] loadVal;
   logic             incEn;
   logic             decEn;
   logic             atEnd;
   logic             advance;
   logic [WIDTH-1:0] endVal;
   logic [WIDTH-1:0] startVal;
   logic [WIDTH-1:0] countVal;

   // Leaving PAUSE steps on the same edge as RUN would, so each hold cycle costs exactly one cycle.
   assign advance  = (state_q != IDLE) && !ctrl_if.stop && !ctrl_if.hold;
   assign endVal   = (dir_q == DN) ? ZERO : term_q;
   assign startVal = (dir_q == DN) ? term_q : ZERO;

   always_comb begin
      loadEn  = 1'b0;
      loadVal = startVal;
      incEn   = 1'b0;
      decEn   = 1'b0;
      if (state_q == IDLE) begin
         if (ctrl_if.start && !ctrl_if.stop) begin
            loadEn  = 1'b1;
            loadVal = (ctrl_if.dir == DN) ? ctrl_if.term : ZERO;
         end
      end else if (advance) begin
         if (atEnd) begin
            loadEn = reload_q;
         end else begin
            incEn = (dir_q == UP);
            decEn = (dir_q == DN);
         end
      end
   end

   updown_count #(
      .WIDTH (WIDTH)
   ) u_count (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (loadEn),
      .load_val_i (loadVal),
      .inc_i      (incEn),
      .dec_i      (decEn),
      .end_val_i  (endVal),
      .count_o    (countVal),
      .at_end_o   (atEnd)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         dir_q    <= UP;
         reload_q <= 1'b0;
         term_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ctrl_if.start && !ctrl_if.stop) begin
                  dir_q    <= ctrl_if.dir;
                  reload_q <= ctrl_if.reload;
                  term_q   <= ctrl_if.term;
                  state_q  <= RUN;
               end
            end
            RUN, PAUSE: begin
               if (ctrl_if.stop) begin
                  state_q <= IDLE;
               end else if (ctrl_if.hold) begin
                  state_q <= PAUSE;
               end else begin
                  state_q <= RUN;
                  if (atEnd) begin
                     done_q <= 1'b1;
                     if (!reload_q) begin
                        state_q <= IDLE;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ctrl_if.count = countVal;
   assign ctrl_if.busy  = (state_q != IDLE);
   assign ctrl_if.done  = done_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: stimulus queues hand-computed count/busy/done, a monitor checks each cycle.
module tb_count_ctrl;

   typedef struct {
      logic [3:0] count;
      logic       busy;
      logic       done;
      string      name;
   } expect_t;

   logic    clk   = 1'b0;
   logic    rst_n = 1'b1;
   expect_t expQ[$];
   int      checks = 0;
   int      passes = 0;

   count_ctrl_if #(.WIDTH(4)) bus ();

   count_ctrl #(
      .WIDTH (4)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .ctrl_if (bus)
   );

   initial forever #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [3:0] aC, input logic aB, input logic aD,
                              input logic [3:0] eC, input logic eB, input logic eD);
      checks++;
      if (aC === eC && aB === eB && aD === eD) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: count/busy/done = %0d/%b/%b, expected %0d/%b/%b",
                  name, aC, aB, aD, eC, eB, eD);
      end
   endtask

   // Drive one cycle of commands and queue what the outputs must show after the next rising edge.
   task automatic applyStimulus(input logic s, input logic st, input logic h, input logic d,
                                input logic r, input logic [3:0] t,
                                input logic [3:0] eC, input logic eB, input logic eD,
                                input string name);
      bus.start  = s;
      bus.stop   = st;
      bus.hold   = h;
      bus.dir    = d;
      bus.reload = r;
      bus.term   = t;
      expQ.push_back('{count: eC, busy: eB, done: eD, name: name});
      @(negedge clk);
   endtask

   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e.name, bus.count, bus.busy, bus.done, e.count, e.busy, e.done);
         end
      end
   end

   initial begin
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.hold   = 1'b0;
      bus.dir    = 1'b0;
      bus.reload = 1'b0;
      bus.term   = 4'd0;
      #2 rst_n = 1'b0;
      #1 checkOutput("reset", bus.count, bus.busy, bus.done, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Up one-shot, term 5, then a restart and stop.
      applyStimulus(1, 0, 0, 0, 0, 4'd5, 4'd0, 1, 0, "up1 start");
      for (int k = 1; k <= 5; k++) applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'(k), 1, 0, "up1 step");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd5, 0, 1, "up1 done");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd5, 0, 0, "up1 idle hold");
      applyStimulus(1, 0, 0, 0, 0, 4'd5, 4'd0, 1, 0, "up1 restart");
      applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0, "up1 stop");

      // Down reload, term 3; start pulses and term changes mid-run are ignored.
      applyStimulus(1, 0, 0, 1, 1, 4'd3, 4'd3, 1, 0, "dn start");
      for (int p = 0; p < 2; p++) begin
         applyStimulus(1, 0, 0, 0, 0, 4'd9, 4'd2, 1, 0, "dn step2");
         applyStimulus(0, 0, 0, 0, 0, 4'd9, 4'd1, 1, 0, "dn step1");
         applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 0, "dn step0");
         applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd3, 1, 1, "dn reload");
      end
      applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd3, 0, 0, "dn stop");

      // Up reload, term 2: count shows 0 while done is high.
      applyStimulus(1, 0, 0, 0, 1, 4'd2, 4'd0, 1, 0, "upr start");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, "upr step1");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd2, 1, 0, "upr step2");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 1, "upr reload");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, "upr step1b");
      applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd1, 0, 0, "upr stop");

      // Hold four cycles at count 2, up term 7: done four cycles late.
      applyStimulus(1, 0, 0, 0, 0, 4'd7, 4'd0, 1, 0, "hold start");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, "hold step1");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd2, 1, 0, "hold step2");
      for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd2, 1, 0, "hold frozen");
      for (int k = 3; k <= 7; k++) applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'(k), 1, 0, "hold resume");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd7, 0, 1, "hold done");

      // Stop and hold together at count 4, then start+stop in IDLE.
      applyStimulus(1, 0, 0, 0, 0, 4'd9, 4'd0, 1, 0, "sh start");
      for (int k = 1; k <= 4; k++) applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'(k), 1, 0, "sh step");
      applyStimulus(0, 1, 1, 0, 0, 4'd0, 4'd4, 0, 0, "sh stop wins");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd4, 0, 0, "sh idle");
      applyStimulus(1, 1, 0, 1, 0, 4'd6, 4'd4, 0, 0, "start+stop");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd4, 0, 0, "start+stop idle");

      // term 0 up one-shot: terminal on the first RUN edge.
      applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 1, 0, "t0 start");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1, "t0 done");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "t0 idle");

      // Asynchronous reset mid-count at count 5.
      applyStimulus(1, 0, 0, 0, 0, 4'd9, 4'd0, 1, 0, "rst start");
      for (int k = 1; k <= 5; k++) applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'(k), 1, 0, "rst step");
      #2 rst_n = 1'b0;
      #1 checkOutput("mid-run reset", bus.count, bus.busy, bus.done, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, "post-reset idle");
      applyStimulus(1, 0, 0, 0, 0, 4'd2, 4'd0, 1, 0, "post-reset start");
      applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd1, 1, 0, "post-reset step");

      for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
      if (expQ.size() != 0) begin
         checks++;
         $display("[TB] FAIL drain: pending = %0d, expected 0", expQ.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Sequencing controller for the team's counter datapath: accepts start/stop/hold commands, loads a programmable terminal value, and runs a synchronous up or down count to that terminal. It operates in one-shot or auto-reload mode and reports progress through `count`, `busy` and a one-cycle `done` pulse. It sits between the control logic and any consumer that needs a timed or counted sequence, replacing free-running ripple counting with a single-clock, fully synchronous controlled count.

## Interface
- WIDTH, 4: counter and terminal-value width in bits.
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  begin a count; sampled only in IDLE.
- stop  input  1  abort the count and return to IDLE; `count` retains its value.
- hold  input  1  level; pauses counting while high.
- dir  input  1  0 = up (0 → term), 1 = down (term → 0); latched at start.
- reload  input  1  0 = one-shot, 1 = auto-reload; latched at start.
- term  input  WIDTH  terminal value; latched at start.
- count  output  WIDTH  current count value.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse per terminal event.

## Operation
- Reset: state = IDLE, count = 0, busy = 0, done = 0, latched dir/reload/term = 0.
- States:
  - IDLE: `count` holds its value.
    - start=1 and stop=0: latch dir/reload/term, set count = (dir ? term : 0), go to RUN.
  - RUN: condition priority is stop > hold > terminal > step.
    - stop: go to IDLE, count holds.
    - hold: go to PAUSE, count holds.
    - count == endpoint (term if up, 0 if down): terminal event. done <= 1. If reload=1, count = start value and stay in RUN. If reload=0, count holds and go to IDLE.
    - Otherwise count ±1 (+1 if up, −1 if down).
  - PAUSE: count holds.
    - stop: go to IDLE.
    - hold=0: go to RUN; counting resumes on the next edge.
- `start` is ignored outside IDLE. Changes to dir/reload/term during a run have no effect.
- No wrap beyond the endpoint: the terminal check prevents overflow and underflow. Arithmetic is modulo 2^WIDTH on `count` only.
- term = 0: the start value equals the endpoint, so a terminal event occurs on the first RUN edge.
- `done` is a register. It is 0 on every edge without a terminal event.

## Timing
- Start sampled at edge E0: after E0, count = start value and busy = 1.
- Up count, term = N: count = k after edge E0+k. Terminal event at E0+N+1.
  - One-shot: done = 1 and busy = 0 during the cycle after E0+N+1.
  - Reload: period is N+1 cycles. done pulses once per period, and count shows 0 in the same cycle done is high.
- Down count is symmetric: count = N−k after E0+k.
- Each hold cycle adds exactly one cycle of latency. No counts are lost or duplicated.
- `busy` decodes directly from the state register: no combinational path from inputs.
- Reset assertion mid-run forces reset values immediately, without waiting for clk.

## Structure
- Package `count_ctrl_pkg` holds:
  - the state encoding (IDLE, RUN, PAUSE, 2-bit);
  - the default WIDTH;
  - dir encodings UP = 0 and DN = 1.
- One sub-module, `updown_count`, is the natural split. It is the WIDTH-bit register with load, increment, decrement and hold controls, plus an `at_end` compare output.
- `count_ctrl` contains the FSM, the latched configuration registers and the `done` register.

## Test plan
- Reset mid-count (rst low at count = 5, asynchronous to clk) → count = 0, busy = 0 and done = 0 immediately; state is IDLE after rst returns high.
- Up one-shot, term = 5, start one cycle → count = 0,1,2,3,4,5 on successive cycles, then done = 1 for one cycle with busy = 0; count stays 5; a second start with stop=0 restarts from 0.
- Down reload, term = 3 → count = 3,2,1,0,3,2,1,0…; done high in each cycle where count returns to 3; busy stays 1.
- Hold for 4 cycles at count = 2 (up, term = 7) → count frozen at 2 for 4 cycles, resumes at 3; done arrives exactly 4 cycles late.
- stop and hold together at count = 4 → stop wins, so the block goes to IDLE and count holds 4. Start and stop together in IDLE → no start. Start pulsed during RUN → ignored. term changed mid-run → ignored.
- term = 0 with up direction and reload = 0 → count = 0, and done pulses on the next edge.
